// File: rtl/upct_target_compressor.sv
// Compresses 32b BTB branch targets to {UPCT index, lower PC} via the UPCT update0/update1 ports.
// Latency: request accepted in cycle N -> update0 in N+1 -> out_valid in N+2 (U1 bypass when output buffer empty).
// Backpressure: out_ready low fills a 2-slot output stage, then issue stalls, then the input FIFO fills and drops req_ready.
module upct_target_compressor #(
  parameter int UPPER_PC_WIDTH   = 20,
  parameter int LOG_UPCT_ENTRIES = 3,
  parameter int TAG_WIDTH        = 8,
  parameter int REQ_FIFO_DEPTH   = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_target_PC,
  input  logic [TAG_WIDTH-1:0]           req_tag,
  output logic                           update0_valid,
  output logic [31:0]                    update0_start_full_PC,
  input  logic [LOG_UPCT_ENTRIES-1:0]    update1_upct_index,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LOG_UPCT_ENTRIES-1:0]    out_upct_index,
  output logic [32-UPPER_PC_WIDTH-2:0]   out_lower_PC,
  output logic [TAG_WIDTH-1:0]           out_tag
);

  localparam int LOW_W = 32 - UPPER_PC_WIDTH - 1;
  localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------- input FIFO ----------------
  logic [31:0]          fifo_pc  [REQ_FIFO_DEPTH];
  logic [TAG_WIDTH-1:0] fifo_tag [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 issue;
  logic [31:0]          head_pc;
  logic [TAG_WIDTH-1:0] head_tag;

  // req_ready comes only from the registered count, so there is no req_valid->req_ready path.
  assign req_ready = (count != CNT_W'(REQ_FIFO_DEPTH));
  assign push      = req_valid & req_ready;
  assign head_pc   = fifo_pc[rd_ptr];
  assign head_tag  = fifo_tag[rd_ptr];

  // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(issue);
    end
  end

  // FIFO storage; contents are don't-care while the matching slot is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= req_target_PC;
      fifo_tag[wr_ptr] <= req_tag;
    end
  end

  // ---------------- U1 stage ----------------
  logic                      u1_valid;
  logic [UPPER_PC_WIDTH-1:0] u1_upper;
  logic [LOW_W-1:0]          u1_lower;
  logic [TAG_WIDTH-1:0]      u1_tag;

  // ---------------- output buffer ----------------
  logic [LOG_UPCT_ENTRIES-1:0] ob_idx [2];
  logic [LOW_W-1:0]            ob_low [2];
  logic [TAG_WIDTH-1:0]        ob_tag [2];
  logic                        ob_wr;
  logic                        ob_rd;
  logic [1:0]                  ob_count;
  logic                        ob_empty;
  logic                        ob_push;
  logic                        ob_pop;
  logic                        out_fire;

  // ---------------- U0 issue decision ----------------
  logic [2:0] occ;
  logic [2:0] occ_after;
  logic       credit;
  logic       hazard;

  // Items owned by the output stage (buffer + U1) after this cycle's pop; a new issue needs room for one more.
  assign occ       = 3'(ob_count) + 3'(u1_valid);
  assign occ_after = occ - 3'(out_fire);
  assign credit    = (occ_after < 3'd2);
  // The UPCT allocates at the end of update1, so a same-upper request right behind would allocate twice.
  assign hazard    = u1_valid & (u1_upper == head_pc[31:32-UPPER_PC_WIDTH]);
  assign issue     = (count != '0) & credit & ~hazard;

  assign update0_valid         = issue;
  assign update0_start_full_PC = issue ? head_pc : 32'd0;

  // U1 holds the request whose index the UPCT returns this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      u1_valid <= 1'b0;
      u1_upper <= '0;
      u1_lower <= '0;
      u1_tag   <= '0;
    end else begin
      u1_valid <= issue;
      if (issue) begin
        u1_upper <= head_pc[31:32-UPPER_PC_WIDTH];
        u1_lower <= head_pc[31-UPPER_PC_WIDTH:1];
        u1_tag   <= head_tag;
      end
    end
  end

  // Empty buffer lets U1 drive the outputs directly; otherwise U1 is queued behind older entries.
  assign ob_empty  = (ob_count == 2'd0);
  assign out_valid = ~ob_empty | u1_valid;
  assign out_fire  = out_valid & out_ready;
  assign ob_pop    = ~ob_empty & out_ready;
  assign ob_push   = u1_valid & ~(ob_empty & out_ready);

  // Output buffer pointers/occupancy; credit keeps U1 from ever meeting a full buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ob_wr    <= 1'b0;
      ob_rd    <= 1'b0;
      ob_count <= 2'd0;
    end else begin
      if (ob_push) ob_wr <= ~ob_wr;
      if (ob_pop)  ob_rd <= ~ob_rd;
      ob_count <= ob_count + 2'(ob_push) - 2'(ob_pop);
    end
  end

  // Output buffer storage; update1_upct_index is captured only while U1 is valid.
  always_ff @(posedge CLK) begin
    if (ob_push) begin
      ob_idx[ob_wr] <= update1_upct_index;
      ob_low[ob_wr] <= u1_lower;
      ob_tag[ob_wr] <= u1_tag;
    end
  end

  // Output mux: buffer head first, then U1 bypass, zero when nothing is valid.
  always_comb begin
    out_upct_index = '0;
    out_lower_PC   = '0;
    out_tag        = '0;
    if (!ob_empty) begin
      out_upct_index = ob_idx[ob_rd];
      out_lower_PC   = ob_low[ob_rd];
      out_tag        = ob_tag[ob_rd];
    end else if (u1_valid) begin
      out_upct_index = update1_upct_index;
      out_lower_PC   = u1_lower;
      out_tag        = u1_tag;
    end
  end

endmodule
